// File: rtl/ctrl_decode_pipe.sv
// Registered decode/control stage between IF/ID and ID/EX: one-cycle decode with
// bubble/flush handling, a multi-cycle MUL sequencer and sticky illegal-opcode counting.
module ctrl_decode_pipe #(
  parameter int OP_CODE_LEN = 6,
  parameter int EXE_CMD_LEN = 4,
  parameter int MUL_LATENCY = 4,
  parameter int ILL_CNT_W   = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [OP_CODE_LEN-1:0] opCode,
  input  logic                   in_valid,
  input  logic                   hazard_detected,
  input  logic                   flush,
  output logic                   branchEn,
  output logic                   Is_Imm,
  output logic                   ST_or_BNE,
  output logic                   WB_EN,
  output logic                   MEM_R_EN,
  output logic                   MEM_W_EN,
  output logic [EXE_CMD_LEN-1:0] EXE_CMD,
  output logic [1:0]             Branch_command,
  output logic                   ctrl_valid,
  output logic                   busy_stall,
  output logic                   illegal_op,
  output logic [ILL_CNT_W-1:0]   illegal_count
);

  localparam int CNT_W = (MUL_LATENCY > 2) ? $clog2(MUL_LATENCY) : 1;

  localparam logic [OP_CODE_LEN-1:0] OP_NOP  = OP_CODE_LEN'(0);
  localparam logic [OP_CODE_LEN-1:0] OP_ADD  = OP_CODE_LEN'(1);
  localparam logic [OP_CODE_LEN-1:0] OP_MUL  = OP_CODE_LEN'(2);
  localparam logic [OP_CODE_LEN-1:0] OP_SUB  = OP_CODE_LEN'(3);
  localparam logic [OP_CODE_LEN-1:0] OP_AND  = OP_CODE_LEN'(5);
  localparam logic [OP_CODE_LEN-1:0] OP_OR   = OP_CODE_LEN'(6);
  localparam logic [OP_CODE_LEN-1:0] OP_NOR  = OP_CODE_LEN'(7);
  localparam logic [OP_CODE_LEN-1:0] OP_XOR  = OP_CODE_LEN'(8);
  localparam logic [OP_CODE_LEN-1:0] OP_SLA  = OP_CODE_LEN'(9);
  localparam logic [OP_CODE_LEN-1:0] OP_SLL  = OP_CODE_LEN'(10);
  localparam logic [OP_CODE_LEN-1:0] OP_SRA  = OP_CODE_LEN'(11);
  localparam logic [OP_CODE_LEN-1:0] OP_SRL  = OP_CODE_LEN'(12);
  localparam logic [OP_CODE_LEN-1:0] OP_ADDI = OP_CODE_LEN'(32);
  localparam logic [OP_CODE_LEN-1:0] OP_SUBI = OP_CODE_LEN'(33);
  localparam logic [OP_CODE_LEN-1:0] OP_LD   = OP_CODE_LEN'(36);
  localparam logic [OP_CODE_LEN-1:0] OP_ST   = OP_CODE_LEN'(37);
  localparam logic [OP_CODE_LEN-1:0] OP_BEZ  = OP_CODE_LEN'(40);
  localparam logic [OP_CODE_LEN-1:0] OP_BNE  = OP_CODE_LEN'(41);
  localparam logic [OP_CODE_LEN-1:0] OP_JMP  = OP_CODE_LEN'(42);

  localparam logic [EXE_CMD_LEN-1:0] EXE_ADD = EXE_CMD_LEN'(0);
  localparam logic [EXE_CMD_LEN-1:0] EXE_SUB = EXE_CMD_LEN'(2);
  localparam logic [EXE_CMD_LEN-1:0] EXE_MUL = EXE_CMD_LEN'(3);
  localparam logic [EXE_CMD_LEN-1:0] EXE_AND = EXE_CMD_LEN'(4);
  localparam logic [EXE_CMD_LEN-1:0] EXE_OR  = EXE_CMD_LEN'(5);
  localparam logic [EXE_CMD_LEN-1:0] EXE_NOR = EXE_CMD_LEN'(6);
  localparam logic [EXE_CMD_LEN-1:0] EXE_XOR = EXE_CMD_LEN'(7);
  localparam logic [EXE_CMD_LEN-1:0] EXE_SLA = EXE_CMD_LEN'(8);
  localparam logic [EXE_CMD_LEN-1:0] EXE_SLL = EXE_CMD_LEN'(8);
  localparam logic [EXE_CMD_LEN-1:0] EXE_SRA = EXE_CMD_LEN'(9);
  localparam logic [EXE_CMD_LEN-1:0] EXE_SRL = EXE_CMD_LEN'(10);
  localparam logic [EXE_CMD_LEN-1:0] EXE_NOP = EXE_CMD_LEN'(15);

  localparam logic [1:0] COND_JUMP = 2'b10;
  localparam logic [1:0] COND_BEZ  = 2'b11;
  localparam logic [1:0] COND_BNE  = 2'b01;

  typedef enum logic [0:0] {IDLE, MUL} state_t;

  state_t           state;
  logic [CNT_W-1:0] mul_cnt;

  logic                   dec_branch, dec_imm, dec_st_bne, dec_wb, dec_mem_r, dec_mem_w;
  logic [EXE_CMD_LEN-1:0] dec_exe;
  logic [1:0]             dec_bcmd;
  logic                   dec_valid, dec_illegal, dec_mul;

  // Pure opcode table; the NOP opcode decodes to a bubble without being flagged illegal.
  always_comb begin
    dec_branch  = 1'b0;
    dec_imm     = 1'b0;
    dec_st_bne  = 1'b0;
    dec_wb      = 1'b0;
    dec_mem_r   = 1'b0;
    dec_mem_w   = 1'b0;
    dec_exe     = EXE_NOP;
    dec_bcmd    = 2'b00;
    dec_valid   = 1'b1;
    dec_illegal = 1'b0;
    dec_mul     = 1'b0;
    case (opCode)
      OP_NOP:  dec_valid = 1'b0;
      OP_ADD:  begin dec_exe = EXE_ADD; dec_wb = 1'b1; end
      OP_SUB:  begin dec_exe = EXE_SUB; dec_wb = 1'b1; end
      OP_AND:  begin dec_exe = EXE_AND; dec_wb = 1'b1; end
      OP_OR:   begin dec_exe = EXE_OR;  dec_wb = 1'b1; end
      OP_NOR:  begin dec_exe = EXE_NOR; dec_wb = 1'b1; end
      OP_XOR:  begin dec_exe = EXE_XOR; dec_wb = 1'b1; end
      OP_SLA:  begin dec_exe = EXE_SLA; dec_wb = 1'b1; end
      OP_SLL:  begin dec_exe = EXE_SLL; dec_wb = 1'b1; end
      OP_SRA:  begin dec_exe = EXE_SRA; dec_wb = 1'b1; end
      OP_SRL:  begin dec_exe = EXE_SRL; dec_wb = 1'b1; end
      OP_ADDI: begin dec_exe = EXE_ADD; dec_wb = 1'b1; dec_imm = 1'b1; end
      OP_SUBI: begin dec_exe = EXE_SUB; dec_wb = 1'b1; dec_imm = 1'b1; end
      OP_LD: begin
        dec_exe    = EXE_ADD;
        dec_wb     = 1'b1;
        dec_imm    = 1'b1;
        dec_st_bne = 1'b1;
        dec_mem_r  = 1'b1;
      end
      OP_ST: begin
        dec_exe    = EXE_ADD;
        dec_imm    = 1'b1;
        dec_mem_w  = 1'b1;
        dec_st_bne = 1'b1;
      end
      OP_BEZ:  begin dec_imm = 1'b1; dec_branch = 1'b1; dec_bcmd = COND_BEZ; end
      OP_BNE: begin
        dec_imm    = 1'b1;
        dec_branch = 1'b1;
        dec_bcmd   = COND_BNE;
        dec_st_bne = 1'b1;
      end
      OP_JMP:  begin dec_imm = 1'b1; dec_branch = 1'b1; dec_bcmd = COND_JUMP; end
      OP_MUL:  dec_mul = 1'b1;
      default: begin dec_valid = 1'b0; dec_illegal = 1'b1; end
    endcase
  end

  // IDLE defaults every output to a bubble and overrides it; MUL holds its word until done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      mul_cnt        <= '0;
      branchEn       <= 1'b0;
      Is_Imm         <= 1'b0;
      ST_or_BNE      <= 1'b0;
      WB_EN          <= 1'b0;
      MEM_R_EN       <= 1'b0;
      MEM_W_EN       <= 1'b0;
      EXE_CMD        <= EXE_NOP;
      Branch_command <= 2'b00;
      ctrl_valid     <= 1'b0;
      busy_stall     <= 1'b0;
      illegal_op     <= 1'b0;
      illegal_count  <= '0;
    end else begin
      illegal_op <= 1'b0;
      case (state)
        IDLE: begin
          branchEn       <= 1'b0;
          Is_Imm         <= 1'b0;
          ST_or_BNE      <= 1'b0;
          WB_EN          <= 1'b0;
          MEM_R_EN       <= 1'b0;
          MEM_W_EN       <= 1'b0;
          EXE_CMD        <= EXE_NOP;
          Branch_command <= 2'b00;
          ctrl_valid     <= 1'b0;
          busy_stall     <= 1'b0;
          if (!flush && !hazard_detected && in_valid) begin
            if (dec_mul) begin
              state      <= MUL;
              mul_cnt    <= CNT_W'(MUL_LATENCY - 2);
              EXE_CMD    <= EXE_MUL;
              busy_stall <= 1'b1;
            end else if (dec_illegal) begin
              illegal_op <= 1'b1;
              if (illegal_count != {ILL_CNT_W{1'b1}})
                illegal_count <= illegal_count + ILL_CNT_W'(1);
            end else begin
              branchEn       <= dec_branch;
              Is_Imm         <= dec_imm;
              ST_or_BNE      <= dec_st_bne;
              WB_EN          <= dec_wb;
              MEM_R_EN       <= dec_mem_r;
              MEM_W_EN       <= dec_mem_w;
              EXE_CMD        <= dec_exe;
              Branch_command <= dec_bcmd;
              ctrl_valid     <= dec_valid;
            end
          end
        end
        MUL: begin
          if (flush) begin
            state      <= IDLE;
            mul_cnt    <= '0;
            EXE_CMD    <= EXE_NOP;
            WB_EN      <= 1'b0;
            ctrl_valid <= 1'b0;
            busy_stall <= 1'b0;
          end else if (mul_cnt != '0) begin
            mul_cnt <= mul_cnt - CNT_W'(1);
          end else begin
            state      <= IDLE;
            WB_EN      <= 1'b1;
            ctrl_valid <= 1'b1;
            busy_stall <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// Self-checking bench for ctrl_decode_pipe: directed scenarios followed by random
// traffic, compared against a queue-based behavioural model of the decode stage.
module tb_ctrl_decode_pipe;

  localparam int MUL_LAT = 4;
  localparam int ILL_W   = 2;
  localparam int CNT_MAX = (1 << ILL_W) - 1;

  localparam logic [5:0] OP_NOP = 6'd0,  OP_ADD = 6'd1,  OP_MUL = 6'd2,  OP_SUB = 6'd3;
  localparam logic [5:0] OP_AND = 6'd5,  OP_OR = 6'd6,   OP_NOR = 6'd7,  OP_XOR = 6'd8;
  localparam logic [5:0] OP_SLA = 6'd9,  OP_SLL = 6'd10, OP_SRA = 6'd11, OP_SRL = 6'd12;
  localparam logic [5:0] OP_ADDI = 6'd32, OP_SUBI = 6'd33, OP_LD = 6'd36, OP_ST = 6'd37;
  localparam logic [5:0] OP_BEZ = 6'd40, OP_BNE = 6'd41, OP_JMP = 6'd42, OP_BAD = 6'd63;

  localparam logic [3:0] E_ADD = 4'd0, E_SUB = 4'd2, E_MUL = 4'd3, E_AND = 4'd4, E_OR = 4'd5;
  localparam logic [3:0] E_NOR = 4'd6, E_XOR = 4'd7, E_SLA = 4'd8, E_SLL = 4'd8, E_SRA = 4'd9;
  localparam logic [3:0] E_SRL = 4'd10, E_NOP = 4'd15;

  // Word layout: {branchEn, Is_Imm, ST_or_BNE, WB_EN, MEM_R_EN, MEM_W_EN, EXE_CMD, Branch_command,
  //               ctrl_valid, busy_stall, illegal_op}
  localparam logic [14:0] BUBBLE   = {6'b000000, E_NOP, 2'b00, 3'b000};
  localparam logic [14:0] ILL_WORD = {6'b000000, E_NOP, 2'b00, 3'b001};
  localparam logic [14:0] MUL_BUSY = {6'b000000, E_MUL, 2'b00, 3'b010};
  localparam logic [14:0] MUL_WB   = {6'b000100, E_MUL, 2'b00, 3'b100};

  logic             clk = 1'b0;
  logic             rst_n;
  logic [5:0]       op_code;
  logic             in_valid, hazard, flush;
  logic             branch_en, is_imm, st_or_bne, wb_en, mem_r_en, mem_w_en;
  logic [3:0]       exe_cmd;
  logic [1:0]       branch_cmd;
  logic             ctrl_valid, busy_stall, illegal_op;
  logic [ILL_W-1:0] illegal_count;

  int          test_count = 0;
  int          fail_count = 0;
  logic [14:0] exp_word;
  int          exp_cnt;
  logic [14:0] mul_q[$];

  ctrl_decode_pipe #(
    .OP_CODE_LEN(6), .EXE_CMD_LEN(4), .MUL_LATENCY(MUL_LAT), .ILL_CNT_W(ILL_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .opCode(op_code), .in_valid(in_valid),
    .hazard_detected(hazard), .flush(flush),
    .branchEn(branch_en), .Is_Imm(is_imm), .ST_or_BNE(st_or_bne), .WB_EN(wb_en),
    .MEM_R_EN(mem_r_en), .MEM_W_EN(mem_w_en), .EXE_CMD(exe_cmd),
    .Branch_command(branch_cmd), .ctrl_valid(ctrl_valid), .busy_stall(busy_stall),
    .illegal_op(illegal_op), .illegal_count(illegal_count)
  );

  always #5 clk = ~clk;

  function automatic logic [14:0] mk(input logic [5:0] bits, input logic [3:0] exe,
                                     input logic [1:0] bc);
    return {bits, exe, bc, 3'b100};
  endfunction

  // Decode table; bits = {branchEn, Is_Imm, ST_or_BNE, WB_EN, MEM_R_EN, MEM_W_EN}.
  function automatic void spec_decode(input logic [5:0] op, output logic [14:0] w,
                                      output bit legal, output bit is_mul);
    legal  = 1'b1;
    is_mul = 1'b0;
    w      = BUBBLE;
    case (op)
      OP_NOP:  w = BUBBLE;
      OP_ADD:  w = mk(6'b000100, E_ADD, 2'b00);
      OP_SUB:  w = mk(6'b000100, E_SUB, 2'b00);
      OP_AND:  w = mk(6'b000100, E_AND, 2'b00);
      OP_OR:   w = mk(6'b000100, E_OR,  2'b00);
      OP_NOR:  w = mk(6'b000100, E_NOR, 2'b00);
      OP_XOR:  w = mk(6'b000100, E_XOR, 2'b00);
      OP_SLA:  w = mk(6'b000100, E_SLA, 2'b00);
      OP_SLL:  w = mk(6'b000100, E_SLL, 2'b00);
      OP_SRA:  w = mk(6'b000100, E_SRA, 2'b00);
      OP_SRL:  w = mk(6'b000100, E_SRL, 2'b00);
      OP_ADDI: w = mk(6'b010100, E_ADD, 2'b00);
      OP_SUBI: w = mk(6'b010100, E_SUB, 2'b00);
      OP_LD:   w = mk(6'b011110, E_ADD, 2'b00);
      OP_ST:   w = mk(6'b011001, E_ADD, 2'b00);
      OP_BEZ:  w = mk(6'b110000, E_NOP, 2'b11);
      OP_BNE:  w = mk(6'b111000, E_NOP, 2'b01);
      OP_JMP:  w = mk(6'b110000, E_NOP, 2'b10);
      OP_MUL:  is_mul = 1'b1;
      default: legal = 1'b0;
    endcase
  endfunction

  // A MUL is modelled as a queue of the words it still has to present.
  task automatic model_step(input logic [5:0] op, input logic v, input logic hz, input logic fl);
    logic [14:0] w;
    bit legal, is_mul;
    if (mul_q.size() > 0) begin
      if (fl) begin
        mul_q.delete();
        exp_word = BUBBLE;
      end else begin
        exp_word = mul_q.pop_front();
      end
    end else if (fl || hz || !v) begin
      exp_word = BUBBLE;
    end else begin
      spec_decode(op, w, legal, is_mul);
      if (is_mul) begin
        exp_word = MUL_BUSY;
        for (int i = 0; i < MUL_LAT - 2; i++) mul_q.push_back(MUL_BUSY);
        mul_q.push_back(MUL_WB);
      end else if (!legal) begin
        exp_word = ILL_WORD;
        if (exp_cnt < CNT_MAX) exp_cnt++;
      end else begin
        exp_word = w;
      end
    end
  endtask

  task automatic model_reset();
    mul_q.delete();
    exp_word = BUBBLE;
    exp_cnt  = 0;
  endtask

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    test_count++;
    assert (obs === exp) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_output(input string tag);
    logic [14:0] obs;
    obs = {branch_en, is_imm, st_or_bne, wb_en, mem_r_en, mem_w_en, exe_cmd, branch_cmd,
           ctrl_valid, busy_stall, illegal_op};
    check_val({tag, "_word"}, 32'(obs), 32'(exp_word));
    check_val({tag, "_cnt"}, 32'(illegal_count), 32'(exp_cnt));
  endtask

  task automatic apply_stimulus(input string tag, input logic [5:0] op, input logic v,
                                input logic hz, input logic fl);
    op_code  = op;
    in_valid = v;
    hazard   = hz;
    flush    = fl;
    @(posedge clk);
    model_step(op, v, hz, fl);
    #1;
    check_output(tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    op_code = OP_NOP; in_valid = 1'b0; hazard = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    #1;
  endtask

  initial begin
    logic [5:0] ops[20] = '{OP_NOP, OP_ADD, OP_MUL, OP_SUB, OP_AND, OP_OR, OP_NOR, OP_XOR,
                            OP_SLA, OP_SLL, OP_SRA, OP_SRL, OP_ADDI, OP_SUBI, OP_LD, OP_ST,
                            OP_BEZ, OP_BNE, OP_JMP, OP_MUL};
    logic [5:0] op;
    logic       v, hz, fl;

    do_reset();
    check_output("reset");

    apply_stimulus("add_pre", OP_ADD, 1, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_output("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    apply_stimulus("add", OP_ADD, 1, 0, 0);
    check_val("add_exe", 32'(exe_cmd), 32'(E_ADD));

    apply_stimulus("ld_hazard", OP_LD, 1, 1, 0);
    apply_stimulus("ld", OP_LD, 1, 0, 0);
    apply_stimulus("bne_flush", OP_BNE, 1, 1, 1);
    apply_stimulus("bne", OP_BNE, 1, 0, 0);
    check_val("bne_branch_en", 32'(branch_en), 32'd1);

    apply_stimulus("mul_1", OP_MUL, 1, 0, 0);
    check_val("mul_1_busy", 32'(busy_stall), 32'd1);
    apply_stimulus("mul_2", OP_ADD, 1, 1, 0);
    check_val("mul_2_busy", 32'(busy_stall), 32'd1);
    apply_stimulus("mul_3", OP_LD, 0, 0, 0);
    check_val("mul_3_busy", 32'(busy_stall), 32'd1);
    apply_stimulus("mul_wb", OP_SUB, 1, 1, 0);
    check_val("mul_wb_en", 32'({wb_en, ctrl_valid, busy_stall}), 32'b110);
    apply_stimulus("after_mul", OP_XOR, 1, 0, 0);

    apply_stimulus("abort_1", OP_MUL, 1, 0, 0);
    apply_stimulus("abort_2", OP_ADD, 1, 0, 0);
    apply_stimulus("abort_flush", OP_ADD, 1, 0, 1);
    check_val("abort_busy", 32'(busy_stall), 32'd0);
    apply_stimulus("abort_sub", OP_SUB, 1, 0, 0);

    apply_stimulus("ill_invalid", OP_BAD, 0, 0, 0);
    apply_stimulus("ill_hazard", OP_BAD, 1, 1, 0);
    apply_stimulus("ill_flush", OP_BAD, 1, 0, 1);
    for (int i = 0; i < 5; i++) begin
      apply_stimulus("ill_burst", OP_BAD + 6'(0), 1, 0, 0);
      check_val("ill_pulse", 32'(illegal_op), 32'd1);
      check_val("ill_count_seq", 32'(illegal_count), (i < 3) ? 32'(i + 1) : 32'd3);
    end
    apply_stimulus("ill_invalid_sat", OP_BAD, 0, 0, 0);
    check_val("ill_no_pulse", 32'(illegal_op), 32'd0);

    do_reset();
    check_output("reset_2");
    for (int i = 0; i < 400; i++) begin
      op = ($urandom_range(0, 9) < 8) ? ops[$urandom_range(0, 19)] : 6'($urandom_range(0, 63));
      v  = ($urandom_range(0, 9) != 0);
      hz = ($urandom_range(0, 9) == 0);
      fl = ($urandom_range(0, 14) == 0);
      apply_stimulus("random", op, v, hz, fl);
    end

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
